// File: rtl/serv_rf_ram_ff.sv
// serv_rf_ram_ff: flip-flop RF storage with post-reset zero fill, 1-cycle read and per-word parity
module serv_rf_ram_ff #(
    parameter int width     = 8,
    parameter int csr_regs  = 4,
    parameter int depth     = (32 + csr_regs) * 32 / width,
    parameter int aw        = $clog2(depth),
    parameter int parity_en = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic             o_init_done,
    output logic             o_perr,
    input  logic             i_perr_clr,
    input  logic             i_perr_inj
);
    localparam logic [aw:0]   DEPTH_W = (aw + 1)'(depth);
    localparam logic [aw-1:0] LAST    = aw'(depth - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [aw-1:0]    cnt;
    logic [width-1:0] mem [depth];
    logic             run, w_in, r_in, we, byp;
    logic [aw-1:0]    wa;
    logic [width-1:0] wd, rd_nxt;

    assign run    = state == RUN;
    assign w_in   = {1'b0, i_waddr} < DEPTH_W;
    assign r_in   = {1'b0, i_raddr} < DEPTH_W;
    assign we     = !run || (i_wen && w_in);
    assign wa     = run ? i_waddr : cnt;
    assign wd     = run ? i_wdata : '0;
    assign byp    = run && i_ren && i_wen && w_in && (i_waddr == i_raddr);
    assign rd_nxt = byp ? i_wdata : r_in ? mem[i_raddr] : '0;

    // storage array: zero-fill writes during INIT, user writes in RUN; deliberately unreset
    always_ff @(posedge i_clk)
        if (we) mem[wa] <= wd;

    // control: zero-fill sequencing, init-done flag and registered read port
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            o_init_done <= 1'b0;
            o_rdata     <= '0;
        end else if (!run) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state       <= RUN;
                o_init_done <= 1'b1;
            end
        end else if (i_ren) begin
            o_rdata <= rd_nxt;
        end

    if (parity_en != 0) begin : g_par
        logic par [depth];
        logic chk, perr_q;
        assign chk    = run && i_ren && r_in && !byp && ((^mem[i_raddr]) != par[i_raddr]);
        assign o_perr = perr_q;
        // parity array: even parity of each written word, optionally corrupted by the inject hook
        always_ff @(posedge i_clk)
            if (we) par[wa] <= run && ((^i_wdata) ^ i_perr_inj);
        // sticky error flag; a new error outranks a same-cycle clear
        always_ff @(posedge i_clk or negedge i_rst_n)
            if (!i_rst_n) perr_q <= 1'b0;
            else          perr_q <= chk || (perr_q && !(run && i_perr_clr));
    end else begin : g_nopar
        assign o_perr = 1'b0;
    end
endmodule

// File: tb/tb_serv_rf_ram_ff.sv
// tb_serv_rf_ram_ff: directed self-checking bench for serv_rf_ram_ff
module tb_serv_rf_ram_ff;
    localparam int W  = 8;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [AW-1:0] i_waddr = '0;
    logic [W-1:0]  i_wdata = '0;
    logic          i_wen = 1'b0;
    logic [AW-1:0] i_raddr = '0;
    logic          i_ren = 1'b0;
    logic [W-1:0]  o_rdata;
    logic          o_init_done;
    logic          o_perr;
    logic          i_perr_clr = 1'b0;
    logic          i_perr_inj = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n;

    serv_rf_ram_ff #(.width(W), .csr_regs(4), .parity_en(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wen(i_wen),
        .i_raddr(i_raddr), .i_ren(i_ren),
        .o_rdata(o_rdata), .o_init_done(o_init_done), .o_perr(o_perr),
        .i_perr_clr(i_perr_clr), .i_perr_inj(i_perr_inj)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        i_raddr = a;
        i_ren = 1'b1;
        step();
        i_ren = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic inj);
        i_waddr = a;
        i_wdata = d;
        i_wen = 1'b1;
        i_perr_inj = inj;
        step();
        i_wen = 1'b0;
        i_perr_inj = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!o_init_done && cnt < 400) begin
            @(posedge i_clk);
            #1;
            cnt++;
        end
    endtask

    initial begin
        #12;
        check("rst_rdata", o_rdata, 0);
        check("rst_done", o_init_done, 0);
        check("rst_perr", o_perr, 0);
        step();
        i_rst_n = 1'b1;
        wait_done(n);
        check("init_edges", n, 144);
        step();
        for (int a = 0; a < 144; a++) begin
            rd(AW'(a));
            check($sformatf("fill_%0d", a), o_rdata, 0);
        end
        check("fill_perr", o_perr, 0);

        wr(8'h21, 8'hA5, 1'b0);
        i_raddr = 8'h21;
        i_ren = 1'b1;
        #1 check("lat_pre", o_rdata, 0);
        step();
        i_ren = 1'b0;
        check("lat", o_rdata, 8'hA5);
        i_raddr = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold", o_rdata, 8'hA5);
        end

        i_waddr = 8'h10; i_wdata = 8'h3C; i_wen = 1'b1;
        i_raddr = 8'h10; i_ren = 1'b1;
        step();
        i_wen = 1'b0; i_ren = 1'b0;
        check("byp", o_rdata, 8'h3C);
        check("byp_perr", o_perr, 0);
        rd(8'h21);
        check("rd21", o_rdata, 8'hA5);
        rd(8'h10);
        check("byp_stored", o_rdata, 8'h3C);

        i_waddr = 8'd200; i_wdata = 8'hFF; i_wen = 1'b1;
        i_raddr = 8'd200; i_ren = 1'b1;
        step();
        i_wen = 1'b0; i_ren = 1'b0;
        check("oor_rd", o_rdata, 0);
        rd(8'h00);
        check("oor_00", o_rdata, 0);
        rd(8'h8F);
        check("oor_8f", o_rdata, 0);
        rd(8'd56);
        check("oor_alias", o_rdata, 0);

        i_waddr = 8'h30; i_wdata = 8'h5A; i_wen = 1'b1;
        i_raddr = 8'h21; i_ren = 1'b1;
        step();
        i_wen = 1'b0; i_ren = 1'b0;
        check("indep_rd", o_rdata, 8'hA5);
        rd(8'h30);
        check("b2b_rd", o_rdata, 8'h5A);
        check("b2b_perr", o_perr, 0);

        wr(8'd5, 8'h01, 1'b1);
        i_raddr = 8'd5;
        i_ren = 1'b1;
        #1 check("perr_pre", o_perr, 0);
        step();
        i_ren = 1'b0;
        check("inj_rdata", o_rdata, 8'h01);
        check("inj_perr", o_perr, 1);
        i_perr_clr = 1'b1;
        rd(8'd5);
        i_perr_clr = 1'b0;
        check("set_wins", o_perr, 1);
        i_perr_clr = 1'b1;
        step();
        i_perr_clr = 1'b0;
        check("clr", o_perr, 0);
        wr(8'd6, 8'h07, 1'b0);
        rd(8'd6);
        check("odd_rdata", o_rdata, 8'h07);
        check("odd_perr", o_perr, 0);

        i_waddr = 8'd7; i_wdata = 8'h01; i_wen = 1'b1; i_perr_inj = 1'b1;
        i_raddr = 8'd7; i_ren = 1'b1;
        step();
        i_wen = 1'b0; i_ren = 1'b0; i_perr_inj = 1'b0;
        check("byp_inj_rdata", o_rdata, 8'h01);
        check("byp_inj_perr", o_perr, 0);
        rd(8'd7);
        check("inj7_perr", o_perr, 1);

        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_rdata", o_rdata, 0);
        check("arst_done", o_init_done, 0);
        check("arst_perr", o_perr, 0);
        i_waddr = 8'h21; i_wdata = 8'hEE; i_wen = 1'b1;
        i_raddr = 8'h21; i_ren = 1'b1; i_perr_inj = 1'b1;
        step();
        i_rst_n = 1'b1;
        repeat (70) @(posedge i_clk);
        #1;
        check("init_rdata", o_rdata, 0);
        check("init_done70", o_init_done, 0);
        check("init_perr", o_perr, 0);
        #2 i_rst_n = 1'b0;
        #1 check("mid_done", o_init_done, 0);
        i_wen = 1'b0; i_ren = 1'b0; i_perr_inj = 1'b0;
        step();
        i_rst_n = 1'b1;
        wait_done(n);
        check("reinit_edges", n, 144);
        step();
        rd(8'h30);
        check("refill_30", o_rdata, 0);
        rd(8'h21);
        check("refill_21", o_rdata, 0);
        rd(8'd5);
        check("refill_5", o_rdata, 0);
        check("refill_perr", o_perr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
